// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 3-sample mid-bit majority vote, 5..MAX_DATA_W data
// bits, even/odd/stick parity, 1 or 2 stop bits, break and overrun detection,
// and a valid/ack hand-off of each received frame.
module uart_rx_param #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned MAX_DATA_W  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic                  sample_tick,
    input  logic                  enable,
    input  logic [3:0]            data_bits,
    input  logic                  stop_bits,
    input  logic                  parity_en,
    input  logic                  parity_even,
    input  logic                  stick_parity,
    input  logic                  data_ack,
    output logic                  data_valid,
    output logic [MAX_DATA_W-1:0] data_out,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  break_det,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int unsigned TC_W = $clog2(OVERSAMPLE);
    localparam int unsigned MID  = OVERSAMPLE / 2;
    localparam int unsigned BI_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK_WAIT
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [TC_W-1:0]         r_tc;
    logic                    r_s0, r_s1;
    logic [BI_W-1:0]         r_nbits, r_bit_idx, w_nbits_clamped;
    logic                    r_par_en, r_par_even, r_stick, r_two_stop;
    logic [MAX_DATA_W-1:0]   r_shift;
    logic                    r_par_bit, r_framing;
    logic                    r_valid, r_pe, r_fe, r_brk, r_ovr, r_busy;
    logic [MAX_DATA_W-1:0]   r_data;
    logic                    w_rxs, w_vote, w_vote_tick, w_wrap_tick;
    logic                    w_par_exp, w_is_break;
    logic                    w_start, w_done, w_brk;

    assign w_rxs       = r_sync[SYNC_STAGES-1];
    assign w_vote_tick = sample_tick && (r_tc == TC_W'(MID + 1));
    assign w_wrap_tick = sample_tick && (r_tc == TC_W'(OVERSAMPLE - 1));
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_par_exp   = r_stick ? ~r_par_even : ((^r_shift) ^ ~r_par_even);
    assign w_is_break  = (r_shift == '0) && !(r_par_en && r_par_bit) && !w_vote;

    assign data_valid  = r_valid;
    assign data_out    = r_data;
    assign parity_err  = r_pe;
    assign framing_err = r_fe;
    assign break_det   = r_brk;
    assign overrun_err = r_ovr;
    assign busy        = r_busy;

    // Character length clamped to the supported range
    always_comb begin
        w_nbits_clamped = data_bits;
        if (data_bits < 4'd5)
            w_nbits_clamped = 4'd5;
        else if (data_bits > BI_W'(MAX_DATA_W))
            w_nbits_clamped = BI_W'(MAX_DATA_W);
    end

    // rxd synchroniser, idles high
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and frame strobes; enable low aborts any frame
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_brk       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_tick && !w_rxs) begin
                    w_state_nxt = S_START;
                    w_start     = 1'b1;
                end
            end
            S_START: begin
                if (w_vote_tick && w_vote) w_state_nxt = S_IDLE;
                else if (w_wrap_tick)      w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_wrap_tick && (r_bit_idx == r_nbits - BI_W'(1)))
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                if (w_wrap_tick) w_state_nxt = S_STOP1;
            end
            S_STOP1: begin
                if (w_vote_tick) begin
                    if (w_is_break) begin
                        w_done      = 1'b1;
                        w_brk       = 1'b1;
                        w_state_nxt = S_BREAK_WAIT;
                    end else if (!r_two_stop) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_wrap_tick) begin
                    w_state_nxt = S_STOP2;
                end
            end
            S_STOP2: begin
                if (w_vote_tick) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_BREAK_WAIT: begin
                if (sample_tick && w_rxs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_start     = 1'b0;
            w_done      = 1'b0;
            w_brk       = 1'b0;
        end
    end

    // Tick counter and the two early vote samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc <= '0;
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            if (w_start)
                r_tc <= TC_W'(1);
            else if (w_state_nxt == S_IDLE || w_state_nxt == S_BREAK_WAIT)
                r_tc <= '0;
            else if (sample_tick)
                r_tc <= (r_tc == TC_W'(OVERSAMPLE - 1)) ? '0 : r_tc + TC_W'(1);
            if (sample_tick && r_tc == TC_W'(MID - 1)) r_s0 <= w_rxs;
            if (sample_tick && r_tc == TC_W'(MID))     r_s1 <= w_rxs;
        end
    end

    // Frame configuration capture and bit assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nbits    <= '0;
            r_par_en   <= 1'b0;
            r_par_even <= 1'b0;
            r_stick    <= 1'b0;
            r_two_stop <= 1'b0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_bit  <= 1'b0;
            r_framing  <= 1'b0;
        end else begin
            if (w_start) begin
                r_nbits    <= w_nbits_clamped;
                r_par_en   <= parity_en;
                r_par_even <= parity_even;
                r_stick    <= stick_parity;
                r_two_stop <= stop_bits;
                r_shift    <= '0;
                r_bit_idx  <= '0;
                r_par_bit  <= 1'b0;
                r_framing  <= 1'b0;
            end
            if (r_state == S_DATA && w_vote_tick) begin
                for (int i = 0; i < int'(MAX_DATA_W); i++)
                    if (r_bit_idx == BI_W'(i)) r_shift[i] <= w_vote;
            end
            if (r_state == S_DATA && w_wrap_tick)   r_bit_idx <= r_bit_idx + BI_W'(1);
            if (r_state == S_PARITY && w_vote_tick) r_par_bit <= w_vote;
            if (r_state == S_STOP1 && w_vote_tick)  r_framing <= !w_vote;
        end
    end

    // Output holding registers with valid/ack and overrun handling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_brk   <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_done) begin
                if (!r_valid || data_ack) begin
                    r_data  <= w_brk ? '0 : r_shift;
                    r_pe    <= !w_brk && r_par_en && (r_par_bit != w_par_exp);
                    r_fe    <= w_brk || !w_vote || r_framing;
                    r_brk   <= w_brk;
                    r_valid <= 1'b1;
                    r_ovr   <= 1'b0;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (data_ack && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed and randomized frames checked
// against a frame-level reference model of the receiver's held outputs.
module tb_uart_rx_param;

    localparam int OS   = 16;
    localparam int MW   = 8;
    localparam int TDIV = 4;
    localparam int MID  = OS / 2;

    logic          clk = 1'b0;
    logic          rst, rxd, sample_tick, enable;
    logic [3:0]    data_bits;
    logic          stop_bits, parity_en, parity_even, stick_parity, data_ack;
    logic          data_valid, parity_err, framing_err, break_det, overrun_err, busy;
    logic [MW-1:0] data_out;

    int n_vec  = 0;
    int n_miss = 0;

    // reference model of the held frame
    logic          m_valid, m_pe, m_fe, m_brk, m_ovr;
    logic [MW-1:0] m_data;

    always #5 clk = ~clk;

    uart_rx_param #(.OVERSAMPLE(OS), .MAX_DATA_W(MW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .sample_tick(sample_tick), .enable(enable),
        .data_bits(data_bits), .stop_bits(stop_bits), .parity_en(parity_en),
        .parity_even(parity_even), .stick_parity(stick_parity), .data_ack(data_ack),
        .data_valid(data_valid), .data_out(data_out), .parity_err(parity_err),
        .framing_err(framing_err), .break_det(break_det), .overrun_err(overrun_err),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"},   32'(data_valid),  32'(m_valid));
        chk({tag, ".data"},    32'(data_out),    32'(m_data));
        chk({tag, ".parity"},  32'(parity_err),  32'(m_pe));
        chk({tag, ".framing"}, 32'(framing_err), 32'(m_fe));
        chk({tag, ".break"},   32'(break_det),   32'(m_brk));
        chk({tag, ".overrun"}, 32'(overrun_err), 32'(m_ovr));
    endtask

    task automatic model_reset();
        m_valid = 0; m_pe = 0; m_fe = 0; m_brk = 0; m_ovr = 0; m_data = '0;
    endtask

    // a completed frame is taken if the holding slot is free or acked that cycle
    task automatic model_complete(input logic [MW-1:0] d, input logic pe, input logic fe,
                                  input logic brk, input bit ack);
        if (!m_valid || ack) begin
            m_data = d; m_pe = pe; m_fe = fe; m_brk = brk; m_valid = 1; m_ovr = 0;
        end else begin
            m_ovr = 1;
        end
    endtask

    // drive n tick slots of a line level; each slot is TDIV clocks ending in a tick
    task automatic slots(input logic val, input int n, input int glitch, input int ack_slot,
                         input bit lat);
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < TDIV; c++) begin
                @(negedge clk);
                if (lat && s == MID + 2 && c == 0) chk("latency_after", 32'(data_valid), 32'd1);
                if (c == 0) rxd = (s == glitch) ? ~val : val;
                sample_tick = (c == TDIV - 1);
                data_ack    = (s == ack_slot) && (c == TDIV - 1);
                if (lat && s == MID + 1 && c == TDIV - 1)
                    chk("latency_before", 32'(data_valid), 32'd0);
            end
        end
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        sample_tick = 0;
        data_ack    = 1;
        @(negedge clk);
        data_ack = 0;
        if (m_valid) begin
            m_valid = 0;
            m_ovr   = 0;
        end
        check_outputs(tag);
    endtask

    function automatic int clamp_bits(input logic [3:0] db);
        if (db < 5) return 5;
        if (db > MW) return MW;
        return int'(db);
    endfunction

    // par_force: -1 sends the correct parity bit, 0/1 force that bit
    task automatic send_frame(input string tag, input logic [7:0] d, input logic [3:0] db,
                              input logic pe, input logic pev, input logic stk,
                              input logic two, input int par_force, input logic st2,
                              input int glitch_bit, input bit ack_done, input bit lat);
        int            n, ones;
        logic          exp_p, p;
        logic [MW-1:0] dm;
        n     = clamp_bits(db);
        dm    = MW'(d & 8'((1 << n) - 1));
        ones  = $countones(dm);
        exp_p = stk ? ~pev : ((ones % 2 == 1) ^ ~pev);
        p     = (par_force < 0) ? exp_p : par_force[0];
        data_bits = db; parity_en = pe; parity_even = pev; stick_parity = stk; stop_bits = two;
        slots(1'b0, OS, -1, -1, 0);
        // controls changed mid-frame must not affect this frame
        data_bits = 4'($urandom); parity_en = 1'($urandom); parity_even = 1'($urandom);
        stick_parity = 1'($urandom); stop_bits = 1'($urandom);
        for (int i = 0; i < n; i++)
            slots(dm[i], OS, (i == glitch_bit) ? MID - 1 + int'($urandom_range(0, 2)) : -1, -1, 0);
        if (pe) slots(p, OS, -1, -1, 0);
        if (two) begin
            slots(1'b1, OS, -1, -1, 0);
            slots(st2, OS, -1, ack_done ? MID + 1 : -1, lat);
        end else begin
            slots(1'b1, OS, -1, ack_done ? MID + 1 : -1, lat);
        end
        model_complete(dm, pe && (p != exp_p), two && !st2, 1'b0, ack_done);
        slots(1'b1, OS, -1, -1, 0);
        check_outputs(tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // start bit plus three data bits, leaving the receiver mid-DATA
    task automatic partial_frame();
        data_bits = 4'd8; parity_en = 0; stop_bits = 0;
        slots(1'b0, OS, -1, -1, 0);
        slots(1'b1, OS, -1, -1, 0);
        slots(1'b0, OS, -1, -1, 0);
        slots(1'b1, OS / 2, -1, -1, 0);
    endtask

    task automatic break_frame(input string tag);
        slots(1'b0, 12 * OS, -1, -1, 0);
        model_complete('0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_outputs(tag);
        chk({tag, ".busy_low"}, 32'(busy), 32'd1);
        slots(1'b1, 2, -1, -1, 0);
        chk({tag, ".busy_high"}, 32'(busy), 32'd0);
        slots(1'b1, OS, -1, -1, 0);
        do_ack({tag, ".ack"});
    endtask

    initial begin
        rst = 1; rxd = 1; sample_tick = 0; enable = 1; data_bits = 4'd8; stop_bits = 0;
        parity_en = 0; parity_even = 0; stick_parity = 0; data_ack = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        chk("reset.busy", 32'(busy), 32'd0);
        rst = 0;
        slots(1'b1, OS, -1, -1, 0);

        // 8N1 0xA5 with latency check, acked a few clocks later
        send_frame("8n1_a5", 8'hA5, 4'd8, 0, 0, 0, 0, -1, 1, -1, 0, 1);
        repeat (3) @(negedge clk);
        check_outputs("8n1_a5.hold");
        do_ack("8n1_a5.ack");
        do_ack("ack_idle_ignored");

        // 7E2 parity and second-stop framing
        send_frame("7e2_bad_par", 8'h55, 4'd7, 1, 1, 0, 1, 1, 1, -1, 0, 0);
        do_ack("7e2_bad_par.ack");
        send_frame("7e2_good_par", 8'h55, 4'd7, 1, 1, 0, 1, 0, 1, -1, 0, 0);
        do_ack("7e2_good_par.ack");
        send_frame("7e2_stop2_low", 8'h55, 4'd7, 1, 1, 0, 1, -1, 0, -1, 0, 0);
        do_ack("7e2_stop2_low.ack");
        send_frame("stick_5o1", 8'h1F, 4'd2, 1, 0, 1, 0, 0, 1, -1, 0, 0);
        do_ack("stick_5o1.ack");

        // false start, then a mid-bit glitch inside a data bit
        slots(1'b0, 4, -1, -1, 0);
        chk("false_start.busy", 32'(busy), 32'd1);
        slots(1'b1, 2 * OS, -1, -1, 0);
        check_outputs("false_start");
        chk("false_start.idle", 32'(busy), 32'd0);
        send_frame("glitch", 8'hA5, 4'd8, 0, 0, 0, 0, -1, 1, 3, 0, 0);
        do_ack("glitch.ack");

        // break (8N1 and 8E2), then a clean frame
        data_bits = 4'd8; parity_en = 0; stop_bits = 0;
        break_frame("break_8n1");
        send_frame("after_break", 8'h3C, 4'd8, 0, 0, 0, 0, -1, 1, -1, 0, 0);
        do_ack("after_break.ack");
        data_bits = 4'd8; parity_en = 1; parity_even = 1; stick_parity = 0; stop_bits = 1;
        break_frame("break_8e2");

        // overrun without ack, then ack coinciding with completion
        send_frame("ovr_first", 8'h11, 4'd8, 0, 0, 0, 0, -1, 1, -1, 0, 0);
        send_frame("ovr_second", 8'h22, 4'd8, 0, 0, 0, 0, -1, 1, -1, 0, 0);
        do_ack("ovr.ack");
        send_frame("same_cycle_first", 8'h11, 4'd8, 0, 0, 0, 0, -1, 1, -1, 0, 0);
        send_frame("same_cycle_ack", 8'h22, 4'd8, 0, 0, 0, 0, -1, 1, -1, 1, 0);

        // enable dropped mid-frame with a frame still held
        partial_frame();
        @(negedge clk);
        enable = 0; rxd = 1; sample_tick = 0; data_ack = 0;
        @(negedge clk);
        chk("en_drop.busy", 32'(busy), 32'd0);
        slots(1'b1, 8 * OS, -1, -1, 0);
        enable = 1;
        slots(1'b1, OS, -1, -1, 0);
        check_outputs("en_drop");
        do_ack("en_drop.ack");
        send_frame("after_en", 8'h5A, 4'd8, 0, 0, 0, 0, -1, 1, -1, 0, 0);

        // reset mid-DATA with a frame still held
        partial_frame();
        @(negedge clk);
        rst = 1; rxd = 1; sample_tick = 0; data_ack = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        check_outputs("rst_mid");
        chk("rst_mid.busy", 32'(busy), 32'd0);
        slots(1'b1, OS, -1, -1, 0);
        send_frame("after_rst", 8'h5A, 4'd8, 0, 0, 0, 0, -1, 1, -1, 0, 0);
        do_ack("after_rst.ack");

        // randomized frames
        for (int k = 0; k < 16; k++) begin
            logic [7:0] d;
            logic [3:0] db;
            logic       pe, pev, stk, two, st2;
            int         pf, gb;
            d   = 8'($urandom);
            db  = 4'($urandom_range(0, 15));
            if ((d & 8'((1 << clamp_bits(db)) - 1)) == 0) d[0] = 1'b1;
            pe  = 1'($urandom); pev = 1'($urandom); stk = 1'($urandom); two = 1'($urandom);
            pf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
            st2 = !(two && $urandom_range(0, 3) == 0);
            gb  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, clamp_bits(db) - 1)) : -1;
            send_frame($sformatf("rand%0d", k), d, db, pe, pev, stk, two, pf, st2, gb,
                       ($urandom_range(0, 3) == 0), 0);
            if ($urandom_range(0, 3) != 0) do_ack($sformatf("rand%0d.ack", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised second-generation UART receiver for the 16550-compatible core. It oversamples the serial line at a configurable ratio and uses a 3-sample majority vote at mid-bit. It supports 5..MAX_DATA_W data bits, even/odd/stick parity, and 1 or 2 stop bits, with break detection and overrun detection. It sits between the baud generator (sample_tick) and the RX FIFO/LSR logic, and hands off each frame through a valid/ack handshake.

Parameters:
OVERSAMPLE, 16, sample_tick pulses per bit period; even, 8..32
MAX_DATA_W, 8, widest supported character; 5..9
SYNC_STAGES, 2, flops in the rxd synchroniser; >=2

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
rxd  in  1  asynchronous serial input, idle high
sample_tick  in  1  one-clk pulse, OVERSAMPLE per bit
enable  in  1  receiver enable
data_bits  in  4  character length; clamped to 5..MAX_DATA_W
stop_bits  in  1  0 = one stop bit, 1 = two stop bits
parity_en  in  1  parity bit present
parity_even  in  1  1 = even, 0 = odd
stick_parity  in  1  forced parity bit: expected = ~parity_even
data_ack  in  1  consumer accepts the held frame
data_valid  out  1  frame held on outputs
data_out  out  MAX_DATA_W  received character, LSB-aligned, unused MSBs 0
parity_err  out  1  parity mismatch for the held frame
framing_err  out  1  stop bit sampled low for the held frame
break_det  out  1  held frame was a break
overrun_err  out  1  a frame was lost while data_valid=1
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous): FSM = IDLE, all counters 0; every output 0; synchroniser flops preset to 1.
- rxd passes through SYNC_STAGES flops. All decisions use the synchronised value (rxs).
- Tick counter tc runs 0..OVERSAMPLE-1 and advances only on sample_tick. Bit value = majority of rxs at tc = M-1, M, M+1 (M = OVERSAMPLE/2), latched at tc = M+1.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
- IDLE: with enable=1 and rxs=0 on a sample_tick -> START, tc=1.
- START: vote at mid-bit. Vote 1 = false start -> IDLE, no output. Vote 0 -> DATA at tc wrap.
- DATA: LSB first. After data_bits bits -> PARITY if parity_en, else STOP1.
- PARITY: expected bit:
  - stick_parity=1: ~parity_even
  - else XOR(data) ^ ~parity_even
- STOP1: framing if vote=0.
  - stop_bits=0: frame completes at STOP1 mid-bit vote; FSM returns to IDLE immediately, without waiting for bit end.
  - stop_bits=1: -> STOP2 at tc wrap.
- STOP2: framing_err |= vote=0. Frame completes at the mid-bit vote.
- Break: all data bits, parity (if enabled) and STOP1 vote 0.
  - Frame delivers data_out=0, break_det=1, framing_err=1, parity_err=0.
  - With stop_bits=1 the break is decided at STOP1; STOP2 is skipped.
  - FSM -> BREAK_WAIT; leaves to IDLE only after rxs=1 on a sample_tick.
- Completion (one clk after the completing sample_tick):
  - If data_valid=0 or data_ack=1 that same cycle: load data_out and the three flags; data_valid=1; overrun_err=0.
  - Else: keep old data and flags, set overrun_err=1, discard the new frame.
- data_ack with data_valid=1 and no completion that cycle clears data_valid and overrun_err. data_out and flags hold their values. data_ack with data_valid=0 is ignored.
- enable=0: frame in progress aborts to IDLE on the next clk, no output. data_valid and held data are unaffected.
- data_bits and parity/stop controls are sampled at the start bit. Changes mid-frame take effect on the next frame.
- busy=1 in every state except IDLE.
- Latency: data_valid rises exactly 1 clk after the final mid-bit sample_tick.

Test Plan:
- 8N1, OVERSAMPLE=16, byte 0xA5, ack 3 clk later -> data_valid=1 with data_out=0x0A5 and all errors 0; valid stays until ack, then 0.
- 7E2, char 0x55 with parity bit 1 -> parity_err=1. Same char with parity 0 -> parity_err=0. Second stop low -> framing_err=1.
- Glitch: rxd low for 4 ticks then high -> false start, IDLE, no data_valid. Single-tick glitch at mid-bit inside a data bit -> majority vote restores the correct bit.
- Break: rxd low for 12 bit times then high (8N1) -> data_out=0, break_det=1, framing_err=1; busy stays 1 until rxd rises, then a following 0x3C is received cleanly.
- Overrun: two back-to-back frames 0x11, 0x22 with no ack -> data_out=0x11, overrun_err=1. Ack on the same cycle as the second completion -> data_out=0x22, overrun_err=0.
- rst asserted mid-DATA and enable dropped mid-frame -> all outputs 0 (rst) or no frame delivered (enable). The next frame 0x5A is received correctly.
